// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline-control definitions: hazard FSM states, forwarding selects
// and the state-to-stall/clear decode used by hazard_ctrl_unit.
package riscv_defines;

    typedef enum logic [2:0] {
        HCU_RESET        = 3'd0,
        HCU_WORK         = 3'd1,
        HCU_LOAD_USE     = 3'd2,
        HCU_LOAD_WAIT    = 3'd3,
        HCU_MC_WAIT      = 3'd4,
        HCU_BRANCH_FLUSH = 3'd5,
        HCU_JUMP_FLUSH   = 3'd6,
        HCU_POST_FLUSH   = 3'd7
    } hcu_state_e;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_NONE = 2'b00;
    localparam fwd_sel_t FWD_EX   = 2'b01;
    localparam fwd_sel_t FWD_WB   = 2'b10;

    typedef struct packed {
        logic fetch_stall;
        logic if_to_id_stall;
        logic id_to_ex_stall;
        logic ex_to_wb_stall;
        logic if_to_id_clear;
        logic id_to_ex_clear;
        logic ex_to_wb_clear;
    } hcu_ctrl_t;

    // Controls follow the state being entered; sitting in RESET flushes everything
    function automatic hcu_ctrl_t hcu_ctrl(hcu_state_e cur, hcu_state_e nxt);
        hcu_ctrl_t c;
        c = '0;
        if (cur == HCU_RESET) begin
            c.if_to_id_clear = 1'b1;
            c.id_to_ex_clear = 1'b1;
            c.ex_to_wb_clear = 1'b1;
        end else begin
            case (nxt)
                HCU_RESET, HCU_BRANCH_FLUSH: begin
                    c.if_to_id_clear = 1'b1;
                    c.id_to_ex_clear = 1'b1;
                    c.ex_to_wb_clear = 1'b1;
                end
                HCU_LOAD_USE: begin
                    c.fetch_stall    = 1'b1;
                    c.if_to_id_stall = 1'b1;
                    c.id_to_ex_clear = 1'b1;
                end
                HCU_LOAD_WAIT: begin
                    c.fetch_stall    = 1'b1;
                    c.if_to_id_stall = 1'b1;
                    c.id_to_ex_stall = 1'b1;
                    c.ex_to_wb_stall = 1'b1;
                end
                HCU_MC_WAIT: begin
                    c.fetch_stall    = 1'b1;
                    c.if_to_id_stall = 1'b1;
                    c.id_to_ex_stall = 1'b1;
                    c.ex_to_wb_clear = 1'b1;
                end
                HCU_JUMP_FLUSH: c.if_to_id_clear = 1'b1;
                HCU_POST_FLUSH: c.if_to_id_stall = 1'b1;
                default: ;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-status inputs and stall/clear/forward outputs of the hazard control unit.
interface hazard_ctrl_unit_if #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned CNT_WIDTH    = 16
);
    logic                               id_valid_i;
    logic [NUM_RD_PORTS-1:0]            id_use_rs_i;
    logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] id_rs_addr_i;
    logic                               ex_write_en_i;
    logic [ADDR_WIDTH-1:0]              ex_write_addr_i;
    logic                               ex_load_i;
    logic                               wb_write_en_i;
    logic [ADDR_WIDTH-1:0]              wb_write_addr_i;
    logic                               wb_load_i;
    logic                               valid_lsu_load_i;
    logic                               mc_busy_i;
    logic                               branch_taken_i;
    logic                               jump_taken_i;

    logic                               fetch_stall_o;
    logic                               if_to_id_stall_o;
    logic                               id_to_ex_stall_o;
    logic                               ex_to_wb_stall_o;
    logic                               if_to_id_clear_o;
    logic                               id_to_ex_clear_o;
    logic                               ex_to_wb_clear_o;
    logic [2*NUM_RD_PORTS-1:0]          fwrd_sel_o;
    logic                               load_timeout_o;
    logic [CNT_WIDTH-1:0]               stall_cnt_o;

    modport master (
        output id_valid_i, id_use_rs_i, id_rs_addr_i, ex_write_en_i, ex_write_addr_i,
               ex_load_i, wb_write_en_i, wb_write_addr_i, wb_load_i, valid_lsu_load_i,
               mc_busy_i, branch_taken_i, jump_taken_i,
        input  fetch_stall_o, if_to_id_stall_o, id_to_ex_stall_o, ex_to_wb_stall_o,
               if_to_id_clear_o, id_to_ex_clear_o, ex_to_wb_clear_o, fwrd_sel_o,
               load_timeout_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_use_rs_i, id_rs_addr_i, ex_write_en_i, ex_write_addr_i,
               ex_load_i, wb_write_en_i, wb_write_addr_i, wb_load_i, valid_lsu_load_i,
               mc_busy_i, branch_taken_i, jump_taken_i,
        output fetch_stall_o, if_to_id_stall_o, id_to_ex_stall_o, ex_to_wb_stall_o,
               if_to_id_clear_o, id_to_ex_clear_o, ex_to_wb_clear_o, fwrd_sel_o,
               load_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl_unit_fwd_port.sv
// Single-operand forwarding comparator: picks EX, then WB, else register file.
module hcu_fwd_port
    import riscv_defines::*;
#(
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  i_use_rs,
    input  logic [ADDR_WIDTH-1:0] i_rs_addr,
    input  logic                  i_ex_write_en,
    input  logic                  i_ex_load,
    input  logic [ADDR_WIDTH-1:0] i_ex_write_addr,
    input  logic                  i_wb_write_en,
    input  logic [ADDR_WIDTH-1:0] i_wb_write_addr,
    output fwd_sel_t              o_fwd_sel
);
    // A load result is not available in EX, so EX only forwards ALU results
    always_comb begin
        o_fwd_sel = FWD_NONE;
        if (i_use_rs && (|i_rs_addr)) begin
            if (i_ex_write_en && !i_ex_load && (i_ex_write_addr == i_rs_addr))
                o_fwd_sel = FWD_EX;
            else if (i_wb_write_en && (i_wb_write_addr == i_rs_addr))
                o_fwd_sel = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: stall/flush FSM, load timeout, stall perf counter
// and per-operand forwarding selects for the IF/ID/EX/WB pipeline.
module hazard_ctrl_unit
    import riscv_defines::*;
#(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned LOAD_TIMEOUT = 15,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_ctrl_unit_if.slave  bus
);
    localparam int unsigned TO_W = (LOAD_TIMEOUT > 0) ? $clog2(LOAD_TIMEOUT + 1) : 1;

    hcu_state_e           r_state;
    hcu_state_e           w_next_state;
    hcu_ctrl_t            w_ctrl;
    logic                 w_load_use;
    logic                 w_to_hit;
    logic [TO_W-1:0]      r_to_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        w_load_use = 1'b0;
        for (int k = 0; k < NUM_RD_PORTS; k++) begin
            if (bus.id_use_rs_i[k] &&
                (bus.id_rs_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == bus.ex_write_addr_i))
                w_load_use = 1'b1;
        end
        w_load_use = w_load_use & bus.ex_load_i & bus.ex_write_en_i &
                     (|bus.ex_write_addr_i) & bus.id_valid_i;
    end

    assign w_to_hit = (LOAD_TIMEOUT != 0) && (r_state == HCU_LOAD_WAIT) &&
                      !bus.valid_lsu_load_i && (r_to_cnt == TO_W'(LOAD_TIMEOUT - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            HCU_RESET: w_next_state = HCU_WORK;
            HCU_WORK: begin
                if (bus.wb_load_i && bus.wb_write_en_i && !bus.valid_lsu_load_i)
                    w_next_state = HCU_LOAD_WAIT;
                else if (bus.mc_busy_i)      w_next_state = HCU_MC_WAIT;
                else if (w_load_use)         w_next_state = HCU_LOAD_USE;
                else if (bus.branch_taken_i) w_next_state = HCU_BRANCH_FLUSH;
                else if (bus.jump_taken_i)   w_next_state = HCU_JUMP_FLUSH;
            end
            HCU_LOAD_USE: w_next_state = HCU_WORK;
            HCU_LOAD_WAIT: begin
                if (bus.valid_lsu_load_i) begin
                    if (bus.branch_taken_i)    w_next_state = HCU_BRANCH_FLUSH;
                    else if (bus.jump_taken_i) w_next_state = HCU_JUMP_FLUSH;
                    else                       w_next_state = HCU_WORK;
                end
            end
            HCU_MC_WAIT: if (!bus.mc_busy_i) w_next_state = HCU_WORK;
            HCU_BRANCH_FLUSH, HCU_JUMP_FLUSH: w_next_state = HCU_POST_FLUSH;
            HCU_POST_FLUSH: w_next_state = HCU_WORK;
            default: w_next_state = HCU_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= HCU_RESET;
        else     r_state <= w_next_state;
    end

    // Counts completed LOAD_WAIT cycles, saturating at the timeout value
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_to_cnt <= '0;
        else if (r_state != HCU_LOAD_WAIT)
            r_to_cnt <= '0;
        else if (r_to_cnt != TO_W'(LOAD_TIMEOUT))
            r_to_cnt <= r_to_cnt + TO_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_ctrl.fetch_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end

    assign w_ctrl = hcu_ctrl(r_state, w_next_state);

    assign bus.fetch_stall_o    = w_ctrl.fetch_stall;
    assign bus.if_to_id_stall_o = w_ctrl.if_to_id_stall;
    assign bus.id_to_ex_stall_o = w_ctrl.id_to_ex_stall;
    assign bus.ex_to_wb_stall_o = w_ctrl.ex_to_wb_stall;
    assign bus.if_to_id_clear_o = w_ctrl.if_to_id_clear;
    assign bus.id_to_ex_clear_o = w_ctrl.id_to_ex_clear;
    assign bus.ex_to_wb_clear_o = w_ctrl.ex_to_wb_clear;
    assign bus.load_timeout_o   = w_to_hit;
    assign bus.stall_cnt_o      = r_stall_cnt;

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_fwd
        fwd_sel_t w_sel;
        hcu_fwd_port #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd (
            .i_use_rs        (bus.id_use_rs_i[k]),
            .i_rs_addr       (bus.id_rs_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .i_ex_write_en   (bus.ex_write_en_i),
            .i_ex_load       (bus.ex_load_i),
            .i_ex_write_addr (bus.ex_write_addr_i),
            .i_wb_write_en   (bus.wb_write_en_i),
            .i_wb_write_addr (bus.wb_write_addr_i),
            .o_fwd_sel       (w_sel)
        );
        assign bus.fwrd_sel_o[2*k +: 2] = (r_state == HCU_RESET) ? FWD_NONE : w_sel;
    end
endmodule
